rdbk_sweep_ctrl: RTL

Sequencer for the decoded single-bit status readback path (4-bit select decode, 4-bit mode field, 5-line group enable, output strobe; returns one bit). On command it sweeps a contiguous, possibly wrapping, range of select codes under a fixed mode and settles each code. It samples the returned bit per code and packs the results into a 16-bit word delivered over a valid/ready handshake. It also checks that the path idles high while the strobe is deasserted.

---
 rtl/rdbk_sweep_ctrl.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/rdbk_sweep_ctrl.sv
// Readback sweep sequencer: idle-level precheck, then settles and samples each
// select code in a (possibly wrapping) range, packing the bits into a 16-bit result.
module rdbk_sweep_ctrl #(
    parameter int SETTLE_CYC = 2
) (
    input  logic        CK,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic [3:0]  mode_i,
    input  logic [3:0]  first_i,
    input  logic [3:0]  last_i,
    output logic        busy_o,
    output logic [3:0]  sel_o,
    output logic [3:0]  mode_o,
    output logic [4:0]  grp_o,
    output logic        strobe_o,
    input  logic        rd_bit_i,
    output logic [15:0] data_o,
    output logic [4:0]  count_o,
    output logic        valid_o,
    input  logic        ready_i,
    output logic        err_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_PRECHK = 2'd1,
        S_CODE   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC);
    localparam logic [4:0] GRP_PRECHK  = 5'b10000;

    state_t      r_state;
    logic        r_busy;
    logic [3:0]  r_sel;
    logic [3:0]  r_mode;
    logic [4:0]  r_grp;
    logic        r_strobe;
    logic [15:0] r_data;
    logic [4:0]  r_count;
    logic        r_valid;
    logic        r_err;
    logic [3:0]  r_ptr;
    logic [3:0]  r_last;
    logic [3:0]  r_settle;

    logic        w_phase_end;
    logic [3:0]  w_ptr_next;
    logic [15:0] w_bit_mask;
    logic [15:0] w_data_next;

    assign w_phase_end = (r_settle == SETTLE_LAST);
    assign w_ptr_next  = r_ptr + 4'd1;

    // One-hot slot for the code currently being captured (count never exceeds 15 here).
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_mask
            assign w_bit_mask[gi] = (r_count[3:0] == 4'(gi));
        end
    endgenerate

    assign w_data_next = (r_data & ~w_bit_mask) | (rd_bit_i ? w_bit_mask : 16'h0000);

    always_ff @(posedge CK or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_busy   <= 1'b0;
            r_sel    <= 4'd0;
            r_mode   <= 4'd0;
            r_grp    <= 5'd0;
            r_strobe <= 1'b0;
            r_data   <= 16'h0000;
            r_count  <= 5'd0;
            r_valid  <= 1'b0;
            r_err    <= 1'b0;
            r_ptr    <= 4'd0;
            r_last   <= 4'd0;
            r_settle <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_last   <= last_i;
                        r_ptr    <= first_i;
                        r_sel    <= first_i;
                        r_mode   <= mode_i;
                        r_grp    <= GRP_PRECHK;
                        r_strobe <= 1'b0;
                        r_data   <= 16'h0000;
                        r_count  <= 5'd0;
                        r_err    <= 1'b0;
                        r_settle <= 4'd0;
                        r_busy   <= 1'b1;
                        r_state  <= S_PRECHK;
                    end
                end
                S_PRECHK: begin
                    if (w_phase_end) begin
                        r_settle <= 4'd0;
                        if (!rd_bit_i) begin
                            // Path not idling high: abort with an empty result.
                            r_err    <= 1'b1;
                            r_grp    <= 5'd0;
                            r_sel    <= 4'd0;
                            r_mode   <= 4'd0;
                            r_strobe <= 1'b0;
                            r_valid  <= 1'b1;
                            r_state  <= S_DONE;
                        end else begin
                            r_strobe <= 1'b1;
                            r_sel    <= r_ptr;
                            r_state  <= S_CODE;
                        end
                    end else begin
                        r_settle <= r_settle + 4'd1;
                    end
                end
                S_CODE: begin
                    if (w_phase_end) begin
                        r_data   <= w_data_next;
                        r_count  <= r_count + 5'd1;
                        r_settle <= 4'd0;
                        if (r_ptr == r_last) begin
                            r_grp    <= 5'd0;
                            r_sel    <= 4'd0;
                            r_mode   <= 4'd0;
                            r_strobe <= 1'b0;
                            r_valid  <= 1'b1;
                            r_state  <= S_DONE;
                        end else begin
                            r_ptr <= w_ptr_next;
                            r_sel <= w_ptr_next;
                        end
                    end else begin
                        r_settle <= r_settle + 4'd1;
                    end
                end
                S_DONE: begin
                    if (ready_i) begin
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy_o   = r_busy;
    assign sel_o    = r_sel;
    assign mode_o   = r_mode;
    assign grp_o    = r_grp;
    assign strobe_o = r_strobe;
    assign data_o   = r_data;
    assign count_o  = r_count;
    assign valid_o  = r_valid;
    assign err_o    = r_err;

endmodule
